ooo_hazard_ctrl: RTL and testbench

Central stall/flush/redirect controller for the out-of-order core: the `hazard_unit` end of the OOO hazard interface. It consumes busy, hazard, mispredict, exception, fence and halt reports from fetch, decode, execute, commit, memory and the completion buffer. It drives every stall, flush and PC-select signal. A small sequencer serialises pipeline-wide events (trap, mret, fence.i, halt) so that at most one redirect is in flight.

---
 rtl/rv32i_types_pkg.sv | 37 +++
 rtl/ooo_ifence_seq.sv | 32 +++
 rtl/ooo_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ooo_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared types for the OOO hazard controller: functional-unit ids, the
// hazard sequencer state encoding and the fu_type -> busy-flag select.
package rv32i_types_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LS  = 2'd3
    } scalar_fu_t;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_MISP     = 3'd1,
        S_TRAP     = 3'd2,
        S_IF_DRAIN = 3'd3,
        S_IF_WAIT  = 3'd4,
        S_HALTED   = 3'd5
    } hazard_state_t;

    localparam logic [31:0] HZ_RESET_PC = 32'h0000_0200;

    // Busy flag of the unit the decoded instruction wants.
    function automatic logic fu_busy_sel(scalar_fu_t fu, logic busy_au,
                                         logic busy_mu, logic busy_du,
                                         logic busy_ls);
        logic b;
        case (fu)
            FU_ALU:  b = busy_au;
            FU_MUL:  b = busy_mu;
            FU_DIV:  b = busy_du;
            default: b = busy_ls;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ooo_ifence_seq.sv
// fence.i handshake decode: in IF_DRAIN waits for the ROB to empty and
// pulses the cache flush request; in IF_WAIT waits for both caches to
// report flushed. An exception at the ROB head aborts either phase.
// The owning state register lives in ooo_hazard_ctrl.
module ooo_ifence_seq
    import rv32i_types_pkg::*;
(
    input  hazard_state_t state,
    input  logic          rob_empty,
    input  logic          dflushed,
    input  logic          iflushed,
    input  logic          exception,
    output logic          ifence_flush,
    output logic          to_wait,
    output logic          done,
    output logic          abort
);

    logic in_drain, in_wait;

    assign in_drain = (state == S_IF_DRAIN);
    assign in_wait  = (state == S_IF_WAIT);

    // Abort wins over both handshake steps; flush flags only count in IF_WAIT.
    always_comb begin
        abort        = (in_drain | in_wait) & exception;
        ifence_flush = in_drain & rob_empty & ~exception;
        to_wait      = ifence_flush;
        done         = in_wait & dflushed & iflushed & ~exception;
    end

endmodule

// File: rtl/ooo_hazard_ctrl.sv
// Central stall/flush/redirect controller for the OOO core.
// Serialises trap/mret/interrupt, mispredict, fence.i and halt so that
// only one redirect is in flight. Outputs are combinational from inputs
// and state; state and the held privileged PC are registered.
// Build option: define OOO_HAZARD_INTR_EN to accept interrupts
// (intr_req); otherwise intr_req is ignored and intr is tied low.
module ooo_hazard_ctrl
    import rv32i_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = HZ_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_mem_busy,
    input  logic        d_mem_busy,
    input  logic        data_hazard,
    input  scalar_fu_t  fu_type,
    input  logic        busy_au,
    input  logic        busy_mu,
    input  logic        busy_du,
    input  logic        busy_ls,
    input  logic        rob_full,
    input  logic        rob_empty,
    input  logic        mispredict,
    input  logic        exception,
    input  logic        ret,
    input  logic        intr_req,
    input  logic [31:0] mtvec,
    input  logic [31:0] epc,
    input  logic        ifence,
    input  logic        halt,
    input  logic        dflushed,
    input  logic        iflushed,
    output logic        pc_en,
    output logic        stall_fetch_decode,
    output logic        stall_de,
    output logic        stall_commit,
    output logic        fetch_decode_flush,
    output logic        decode_execute_flush,
    output logic        execute_commit_flush,
    output logic        npc_sel,
    output logic        insert_priv_pc,
    output logic [31:0] priv_pc,
    output logic        ifence_flush,
    output logic        intr
);

    hazard_state_t state, state_nx;
    logic [31:0]   priv_pc_q, priv_pc_nx;
    logic          fu_stall;
    logic          intr_ok, intr_wait;
    logic          take_trap, use_epc, intr_take;
    logic          if_flush, if_to_wait, if_done, if_abort;

`ifdef OOO_HAZARD_INTR_EN
    // An interrupt is only taken with an empty ROB so no work is lost.
    assign intr_ok   = intr_req & rob_empty;
    assign intr_wait = intr_req & ~rob_empty;
`else
    logic unused_intr_req;
    assign unused_intr_req = intr_req;
    assign intr_ok   = 1'b0;
    assign intr_wait = 1'b0;
`endif

    assign fu_stall = fu_busy_sel(fu_type, busy_au, busy_mu, busy_du, busy_ls);

    ooo_ifence_seq u_ifence_seq (
        .state        (state),
        .rob_empty    (rob_empty),
        .dflushed     (dflushed),
        .iflushed     (iflushed),
        .exception    (exception),
        .ifence_flush (if_flush),
        .to_wait      (if_to_wait),
        .done         (if_done),
        .abort        (if_abort)
    );

    // Event arbitration and per-state stall/flush/select outputs.
    always_comb begin
        state_nx             = state;
        priv_pc_nx           = priv_pc_q;
        stall_fetch_decode   = 1'b0;
        stall_de             = 1'b0;
        stall_commit         = d_mem_busy;
        fetch_decode_flush   = 1'b0;
        decode_execute_flush = 1'b0;
        execute_commit_flush = 1'b0;
        npc_sel              = 1'b0;
        insert_priv_pc       = 1'b0;
        ifence_flush         = 1'b0;
        take_trap            = 1'b0;
        use_epc              = 1'b0;
        intr_take            = 1'b0;

        case (state)
            S_RUN: begin
                if (exception | ret | intr_ok) begin
                    take_trap = 1'b1;
                    use_epc   = ~exception & ret;
                    intr_take = ~exception & ~ret;
                end else if (mispredict) begin
                    npc_sel              = 1'b1;
                    fetch_decode_flush   = 1'b1;
                    decode_execute_flush = 1'b1;
                    state_nx             = S_MISP;
                end else if (intr_wait) begin
                    // Hold decode so the ROB drains before the interrupt.
                    stall_de           = 1'b1;
                    stall_fetch_decode = 1'b1;
                end else if (halt) begin
                    stall_de           = 1'b1;
                    stall_fetch_decode = 1'b1;
                    state_nx           = S_HALTED;
                end else if (ifence) begin
                    stall_de           = 1'b1;
                    stall_fetch_decode = 1'b1;
                    state_nx           = S_IF_DRAIN;
                end else begin
                    stall_de           = data_hazard | rob_full | fu_stall;
                    stall_fetch_decode = stall_de | i_mem_busy;
                end
            end
            S_MISP: begin
                // Bubble cycle while the redirected fetch refills.
                stall_de           = 1'b1;
                stall_fetch_decode = 1'b1;
                state_nx           = S_RUN;
            end
            S_TRAP: begin
                // Redirect already issued; wait out the in-flight fetch.
                stall_fetch_decode = 1'b1;
                if (!i_mem_busy) state_nx = S_RUN;
            end
            S_IF_DRAIN, S_IF_WAIT: begin
                stall_de           = 1'b1;
                stall_fetch_decode = 1'b1;
                ifence_flush       = if_flush;
                if (if_abort) begin
                    take_trap = 1'b1;
                end else if (if_to_wait) begin
                    state_nx = S_IF_WAIT;
                end else if (if_done) begin
                    // Stale fetched/decoded words are dropped; fetch resumes
                    // from its own next PC once back in RUN.
                    fetch_decode_flush   = 1'b1;
                    decode_execute_flush = 1'b1;
                    state_nx             = S_RUN;
                end
            end
            S_HALTED: begin
                stall_de           = 1'b1;
                stall_fetch_decode = 1'b1;
                stall_commit       = 1'b1;
            end
            default: begin
                state_nx = S_RUN;
            end
        endcase

        // Privileged redirect: flush everything and let fetch load priv_pc.
        if (take_trap) begin
            stall_de             = 1'b0;
            stall_fetch_decode   = 1'b0;
            fetch_decode_flush   = 1'b1;
            decode_execute_flush = 1'b1;
            execute_commit_flush = 1'b1;
            insert_priv_pc       = 1'b1;
            priv_pc_nx           = use_epc ? epc : mtvec;
            state_nx             = S_TRAP;
        end
    end

    assign pc_en   = ~stall_fetch_decode;
    assign priv_pc = priv_pc_nx;
    assign intr    = intr_take;

    // Sequencer state and held redirect target.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_RUN;
            priv_pc_q <= RESET_PC;
        end else begin
            state     <= state_nx;
            priv_pc_q <= priv_pc_nx;
        end
    end

endmodule

// File: tb/tb_ooo_hazard_ctrl.sv
// Directed-vector bench for ooo_hazard_ctrl. Inputs change 2ns after each
// rising edge; outputs are compared 1ns later, well before the next edge.
module tb_ooo_hazard_ctrl;
    import rv32i_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        i_mem_busy, d_mem_busy, data_hazard;
    scalar_fu_t  fu_type;
    logic        busy_au, busy_mu, busy_du, busy_ls;
    logic        rob_full, rob_empty, mispredict, exception, ret, intr_req;
    logic [31:0] mtvec, epc;
    logic        ifence, halt, dflushed, iflushed;
    logic        pc_en, stall_fetch_decode, stall_de, stall_commit;
    logic        fetch_decode_flush, decode_execute_flush, execute_commit_flush;
    logic        npc_sel, insert_priv_pc, ifence_flush, intr;
    logic [31:0] priv_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ooo_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
        .data_hazard(data_hazard), .fu_type(fu_type), .busy_au(busy_au),
        .busy_mu(busy_mu), .busy_du(busy_du), .busy_ls(busy_ls),
        .rob_full(rob_full), .rob_empty(rob_empty), .mispredict(mispredict),
        .exception(exception), .ret(ret), .intr_req(intr_req), .mtvec(mtvec),
        .epc(epc), .ifence(ifence), .halt(halt), .dflushed(dflushed),
        .iflushed(iflushed), .pc_en(pc_en),
        .stall_fetch_decode(stall_fetch_decode), .stall_de(stall_de),
        .stall_commit(stall_commit), .fetch_decode_flush(fetch_decode_flush),
        .decode_execute_flush(decode_execute_flush),
        .execute_commit_flush(execute_commit_flush), .npc_sel(npc_sel),
        .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc),
        .ifence_flush(ifence_flush), .intr(intr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle();
        i_mem_busy = 0; d_mem_busy = 0; data_hazard = 0; fu_type = FU_ALU;
        busy_au = 0; busy_mu = 0; busy_du = 0; busy_ls = 0;
        rob_full = 0; rob_empty = 1; mispredict = 0; exception = 0; ret = 0;
        intr_req = 0; mtvec = 32'h100; epc = 32'h300; ifence = 0; halt = 0;
        dflushed = 0; iflushed = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        RST = 1;
        tick(); tick();
        RST = 0;
        #1;
        // reset state
        chk("rst_pc_en", pc_en, 1);
        chk("rst_stall_de", stall_de, 0);
        chk("rst_stall_fd", stall_fetch_decode, 0);
        chk("rst_stall_commit", stall_commit, 0);
        chk("rst_flush", {fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 0);
        chk("rst_sel", {npc_sel, insert_priv_pc, ifence_flush, intr}, 0);
        chk("rst_priv_pc", priv_pc, 32'h200);

        // data hazard for exactly 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); data_hazard = 1; #1;
            chk("dh_stall_de", stall_de, 1);
            chk("dh_pc_en", pc_en, 0);
            chk("dh_flush", {fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 0);
        end
        tick(); data_hazard = 0; #1;
        chk("dh_end_stall_de", stall_de, 0);
        chk("dh_end_pc_en", pc_en, 1);

        // structural selects
        tick(); fu_type = FU_MUL; busy_mu = 1; #1;
        chk("fu_mul_busy", stall_de, 1);
        busy_mu = 0; busy_au = 1; #1;
        chk("fu_other_busy", stall_de, 0);
        busy_au = 0; i_mem_busy = 1; #1;
        chk("imem_stall_fd", stall_fetch_decode, 1);
        chk("imem_stall_de", stall_de, 0);
        chk("imem_pc_en", pc_en, 0);
        i_mem_busy = 0; d_mem_busy = 1; rob_full = 1; #1;
        chk("dmem_commit", stall_commit, 1);
        chk("rob_full_stall", stall_de, 1);
        idle();

        // mispredict
        tick(); mispredict = 1; #1;
        chk("misp_npc_sel", npc_sel, 1);
        chk("misp_flush", {fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 3'b110);
        tick(); mispredict = 0; #1;
        chk("misp_bubble", stall_de, 1);
        chk("misp_bubble_sel", npc_sel, 0);
        tick(); #1;
        chk("misp_back_run", {stall_de, pc_en}, 2'b01);

        // exception beats mispredict
        exception = 1; mispredict = 1; #1;
        chk("exc_insert", insert_priv_pc, 1);
        chk("exc_priv_pc", priv_pc, 32'h100);
        chk("exc_flush", {fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 3'b111);
        chk("exc_npc_sel", npc_sel, 0);
        tick(); mispredict = 0; i_mem_busy = 1; #1;
        chk("trap_pc_en", pc_en, 0);
        chk("trap_ignores_exc", insert_priv_pc, 0);
        tick(); exception = 0; i_mem_busy = 0; #1;
        chk("trap_exit_pc_en", pc_en, 0);
        tick(); #1;
        chk("trap_run_pc_en", pc_en, 1);
        chk("trap_held_pc", priv_pc, 32'h100);

        // mret
        ret = 1; #1;
        chk("ret_priv_pc", priv_pc, 32'h300);
        chk("ret_flush", {execute_commit_flush, insert_priv_pc}, 2'b11);
        tick(); ret = 0; #1;
        chk("ret_trap_pc_en", pc_en, 0);
        tick(); #1;
        chk("ret_run_pc", {pc_en, priv_pc}, {1'b1, 32'h300});

        // fence.i handshake
        ifence = 1; rob_empty = 0; #1;
        chk("if_start_stall", {stall_fetch_decode, stall_de, pc_en}, 3'b110);
        chk("if_start_flush", ifence_flush, 0);
        tick(); ifence = 0;
        for (int i = 0; i < 3; i++) begin
            dflushed = (i == 1); #1;
            chk("if_drain_flush", ifence_flush, 0);
            chk("if_drain_stall", stall_de, 1);
            tick();
        end
        dflushed = 0; rob_empty = 1; #1;
        chk("if_pulse", ifence_flush, 1);
        chk("if_pulse_noflush", fetch_decode_flush, 0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            dflushed = (k >= 2); iflushed = (k >= 5); #1;
            chk("if_wait_single_pulse", ifence_flush, 0);
            if (k < 5) begin
                chk("if_wait_noflush", fetch_decode_flush, 0);
                tick();
            end else begin
                chk("if_done_flush", {fetch_decode_flush, decode_execute_flush, execute_commit_flush}, 3'b110);
            end
        end
        tick(); idle(); #1;
        chk("if_back_run", {pc_en, stall_de}, 2'b10);

        // exception aborts a fence
        ifence = 1; tick(); ifence = 0; exception = 1; #1;
        chk("if_abort_insert", {insert_priv_pc, execute_commit_flush, ifence_flush}, 3'b110);
        chk("if_abort_pc", priv_pc, 32'h100);
        tick(); exception = 0; #1;
        chk("if_abort_trap", pc_en, 0);
        tick(); #1;
        chk("if_abort_run", pc_en, 1);

        // interrupt waits for an empty ROB
        mtvec = 32'h180; intr_req = 1; rob_empty = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
`ifdef OOO_HAZARD_INTR_EN
            chk("intr_wait_stall", stall_de, 1);
`else
            chk("intr_wait_stall", stall_de, 0);
`endif
            chk("intr_wait_pulse", intr, 0);
            tick();
        end
        rob_empty = 1; #1;
`ifdef OOO_HAZARD_INTR_EN
        chk("intr_pulse", intr, 1);
        chk("intr_priv_pc", priv_pc, 32'h180);
        chk("intr_insert", insert_priv_pc, 1);
`else
        chk("intr_pulse", intr, 0);
        chk("intr_priv_pc", priv_pc, 32'h100);
        chk("intr_insert", insert_priv_pc, 0);
`endif
        tick(); intr_req = 0; tick(); #1;
        chk("intr_after_run", pc_en, 1);

        // halt, then reset out of HALTED
        halt = 1; #1;
        chk("halt_enter_stall", stall_de, 1);
        tick(); halt = 0; exception = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halted_state", {pc_en, stall_de, stall_fetch_decode, stall_commit}, 4'b0111);
            chk("halted_ignore", insert_priv_pc, 0);
            tick();
        end
        RST = 1; #1;
        chk("halted_pre_rst", pc_en, 0);
        tick(); RST = 0; exception = 0; #1;
        chk("post_rst_pc_en", pc_en, 1);
        chk("post_rst_priv_pc", priv_pc, 32'h200);
        chk("post_rst_commit", stall_commit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
